// File: rtl/uc_recebe_dados.sv
`default_nettype none
// =============================================================================
// Module  : uc_recebe_dados
// Brief   : Receive-side game-state frame deframer fed byte-by-byte by uart_rx.
// Rev     : 1.0  initial release
// =============================================================================
module uc_recebe_dados #(
    parameter int         N_ASTE         = 16,
    parameter int         N_TIROS        = 16,
    parameter int         OPCODE_BYTES   = 4,
    parameter int         RODAPE_BYTES   = 2,
    parameter logic [7:0] RODAPE_BYTE    = 8'hFF,
    parameter int         ADDR_W         = 4,
    parameter int         TIMEOUT_CICLOS = 500000
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      habilita_recepcao,
    input  logic [7:0]                dado_rx,
    input  logic                      pronto_rx,
    output logic                      we_mem_aste,
    output logic                      we_mem_tiro,
    output logic [ADDR_W-1:0]         endereco_mem,
    output logic [7:0]                dado_mem,
    output logic [7:0]                pontuacao,
    output logic [7:0]                opcode_nave,
    output logic [7:0]                jogada_especial,
    output logic [8*OPCODE_BYTES-1:0] opcodes_aste,
    output logic [8*OPCODE_BYTES-1:0] opcodes_tiro,
    output logic                      quadro_valido,
    output logic                      erro_rodape,
    output logic                      erro_timeout,
    output logic                      ocupado,
    output logic [3:0]                db_estado
);

    localparam int MAX_POS = (N_ASTE > N_TIROS) ? N_ASTE : N_TIROS;
    localparam int MAX_AUX = (OPCODE_BYTES > RODAPE_BYTES) ? OPCODE_BYTES : RODAPE_BYTES;
    localparam int MAX_IDX = (MAX_POS > MAX_AUX) ? MAX_POS : MAX_AUX;
    localparam int IDX_W   = $clog2(MAX_IDX + 1);
    localparam int TO_W    = $clog2(TIMEOUT_CICLOS + 1);

    typedef enum logic [3:0] {
        ESPERA       = 4'd0,
        RX_PONTUACAO = 4'd1,
        RX_NAVE      = 4'd2,
        RX_POS_ASTE  = 4'd3,
        RX_OPC_ASTE  = 4'd4,
        RX_POS_TIRO  = 4'd5,
        RX_OPC_TIRO  = 4'd6,
        RX_ESPECIAL  = 4'd7,
        RX_RODAPE    = 4'd8,
        SINALIZA     = 4'd9,
        ERRO         = 4'd10
    } estado_t;

    estado_t                   estado;
    logic [IDX_W-1:0]          idx;
    logic [TO_W-1:0]           cnt_timeout;
    logic [7:0]                sh_pontuacao;
    logic [7:0]                sh_nave;
    logic [7:0]                sh_especial;
    logic [8*OPCODE_BYTES-1:0] sh_opc_aste;
    logic [8*OPCODE_BYTES-1:0] sh_opc_tiro;

    logic em_quadro;
    logic expira;

    assign em_quadro = (estado >= RX_NAVE) && (estado <= RX_RODAPE);
    // A byte arriving on the terminal count takes priority over the timeout.
    assign expira    = em_quadro && !pronto_rx &&
                       (cnt_timeout == TO_W'(TIMEOUT_CICLOS - 1));

    assign db_estado = estado;
    assign ocupado   = (estado != ESPERA);

    always_ff @(posedge clock) begin
        if (reset) begin
            estado          <= ESPERA;
            idx             <= '0;
            cnt_timeout     <= '0;
            sh_pontuacao    <= '0;
            sh_nave         <= '0;
            sh_especial     <= '0;
            sh_opc_aste     <= '0;
            sh_opc_tiro     <= '0;
            we_mem_aste     <= 1'b0;
            we_mem_tiro     <= 1'b0;
            endereco_mem    <= '0;
            dado_mem        <= '0;
            pontuacao       <= '0;
            opcode_nave     <= '0;
            jogada_especial <= '0;
            opcodes_aste    <= '0;
            opcodes_tiro    <= '0;
            quadro_valido   <= 1'b0;
            erro_rodape     <= 1'b0;
            erro_timeout    <= 1'b0;
        end else begin
            we_mem_aste   <= 1'b0;
            we_mem_tiro   <= 1'b0;
            quadro_valido <= 1'b0;
            erro_rodape   <= 1'b0;
            erro_timeout  <= 1'b0;

            if (em_quadro && !pronto_rx) begin
                cnt_timeout <= cnt_timeout + 1'b1;
            end else begin
                cnt_timeout <= '0;
            end

            if (expira) begin
                estado       <= ERRO;
                erro_timeout <= 1'b1;
                idx          <= '0;
            end else begin
                case (estado)
                    ESPERA: begin
                        if (habilita_recepcao && pronto_rx) begin
                            sh_pontuacao <= dado_rx;
                            idx          <= '0;
                            estado       <= RX_NAVE;
                        end
                    end
                    RX_NAVE: begin
                        if (pronto_rx) begin
                            sh_nave <= dado_rx;
                            idx     <= '0;
                            estado  <= RX_POS_ASTE;
                        end
                    end
                    RX_POS_ASTE: begin
                        if (pronto_rx) begin
                            we_mem_aste  <= 1'b1;
                            endereco_mem <= ADDR_W'(idx);
                            dado_mem     <= dado_rx;
                            if (idx == IDX_W'(N_ASTE - 1)) begin
                                idx    <= '0;
                                estado <= RX_OPC_ASTE;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    RX_OPC_ASTE: begin
                        if (pronto_rx) begin
                            for (int k = 0; k < OPCODE_BYTES; k++) begin
                                if (idx == IDX_W'(k)) sh_opc_aste[8*k +: 8] <= dado_rx;
                            end
                            if (idx == IDX_W'(OPCODE_BYTES - 1)) begin
                                idx    <= '0;
                                estado <= RX_POS_TIRO;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    RX_POS_TIRO: begin
                        if (pronto_rx) begin
                            we_mem_tiro  <= 1'b1;
                            endereco_mem <= ADDR_W'(idx);
                            dado_mem     <= dado_rx;
                            if (idx == IDX_W'(N_TIROS - 1)) begin
                                idx    <= '0;
                                estado <= RX_OPC_TIRO;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    RX_OPC_TIRO: begin
                        if (pronto_rx) begin
                            for (int k = 0; k < OPCODE_BYTES; k++) begin
                                if (idx == IDX_W'(k)) sh_opc_tiro[8*k +: 8] <= dado_rx;
                            end
                            if (idx == IDX_W'(OPCODE_BYTES - 1)) begin
                                idx    <= '0;
                                estado <= RX_ESPECIAL;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    RX_ESPECIAL: begin
                        if (pronto_rx) begin
                            sh_especial <= dado_rx;
                            idx         <= '0;
                            estado      <= RX_RODAPE;
                        end
                    end
                    RX_RODAPE: begin
                        if (pronto_rx) begin
                            if (dado_rx != RODAPE_BYTE) begin
                                idx         <= '0;
                                erro_rodape <= 1'b1;
                                estado      <= ERRO;
                            end else if (idx == IDX_W'(RODAPE_BYTES - 1)) begin
                                // Commit happens on the same edge that enters SINALIZA.
                                pontuacao       <= sh_pontuacao;
                                opcode_nave     <= sh_nave;
                                jogada_especial <= sh_especial;
                                opcodes_aste    <= sh_opc_aste;
                                opcodes_tiro    <= sh_opc_tiro;
                                quadro_valido   <= 1'b1;
                                idx             <= '0;
                                estado          <= SINALIZA;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    SINALIZA: estado <= ESPERA;
                    ERRO:     estado <= ESPERA;
                    default:  estado <= ESPERA;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uc_recebe_dados.sv
`default_nettype none
// =============================================================================
// Module  : tb_uc_recebe_dados
// Brief   : Randomized self-checking bench for uc_recebe_dados against a frame-level model.
// Rev     : 1.0  initial release
// =============================================================================
module tb_uc_recebe_dados;

    localparam int NA   = 4;
    localparam int NT   = 2;
    localparam int OB   = 1;
    localparam int RB   = 2;
    localparam int TO   = 100;
    localparam int AW   = 2;
    localparam int FLEN = 3 + NA + NT + 2*OB + RB;
    localparam int P_A  = 2;
    localparam int O_A  = P_A + NA;
    localparam int P_T  = O_A + OB;
    localparam int O_T  = P_T + NT;
    localparam int P_E  = O_T + OB;
    localparam int P_R  = P_E + 1;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            habilita_recepcao = 1'b1;
    logic [7:0]      dado_rx = 8'h00;
    logic            pronto_rx = 1'b0;
    logic            we_mem_aste, we_mem_tiro;
    logic [AW-1:0]   endereco_mem;
    logic [7:0]      dado_mem, pontuacao, opcode_nave, jogada_especial;
    logic [8*OB-1:0] opcodes_aste, opcodes_tiro;
    logic            quadro_valido, erro_rodape, erro_timeout, ocupado;
    logic [3:0]      db_estado;

    uc_recebe_dados #(
        .N_ASTE(NA), .N_TIROS(NT), .OPCODE_BYTES(OB), .RODAPE_BYTES(RB),
        .RODAPE_BYTE(8'hFF), .ADDR_W(AW), .TIMEOUT_CICLOS(TO)
    ) dut (
        .clock(clock), .reset(reset), .habilita_recepcao(habilita_recepcao),
        .dado_rx(dado_rx), .pronto_rx(pronto_rx),
        .we_mem_aste(we_mem_aste), .we_mem_tiro(we_mem_tiro),
        .endereco_mem(endereco_mem), .dado_mem(dado_mem),
        .pontuacao(pontuacao), .opcode_nave(opcode_nave),
        .jogada_especial(jogada_especial), .opcodes_aste(opcodes_aste),
        .opcodes_tiro(opcodes_tiro), .quadro_valido(quadro_valido),
        .erro_rodape(erro_rodape), .erro_timeout(erro_timeout),
        .ocupado(ocupado), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {int addr; int data; int cyc;} wr_t;
    wr_t aste_q[$];
    wr_t tiro_q[$];
    int  n_qv = 0, n_er = 0, n_et = 0, n_both = 0;
    int  cyc_qv = 0, cyc_er = 0, cyc_et = 0;

    // Observes outputs mid-cycle; counters are cumulative, the sequencer works on deltas.
    always @(negedge clock) begin
        if (we_mem_aste) aste_q.push_back('{int'(endereco_mem), int'(dado_mem), cyc});
        if (we_mem_tiro) tiro_q.push_back('{int'(endereco_mem), int'(dado_mem), cyc});
        if (we_mem_aste && we_mem_tiro) n_both++;
        if (quadro_valido) begin n_qv++; cyc_qv = cyc; end
        if (erro_rodape)   begin n_er++; cyc_er = cyc; end
        if (erro_timeout)  begin n_et++; cyc_et = cyc; end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: committed fields and byte bookkeeping.
    logic [7:0]      m_pont = 8'h00, m_nave = 8'h00, m_esp = 8'h00;
    logic [8*OB-1:0] m_opa = '0, m_opt = '0;
    logic [7:0]      fr[FLEN];
    int              edges[FLEN];
    int              n_sent;

    function automatic int exp_state(input int k);
        if (k < P_A) return 2;
        if (k < O_A) return 3;
        if (k < P_T) return 4;
        if (k < O_T) return 5;
        if (k < P_E) return 6;
        if (k < P_R) return 7;
        return 8;
    endfunction

    task automatic drive(input logic [7:0] b, input bit rec);
        @(posedge clock); #2;
        dado_rx   = b;
        pronto_rx = 1'b1;
        if (rec) begin
            edges[n_sent] = cyc + 1;
            n_sent++;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock); #2;
            pronto_rx = 1'b0;
        end
    endtask

    task automatic check_committed(input string tag);
        check_eq({tag, ":pontuacao"}, pontuacao, m_pont);
        check_eq({tag, ":opcode_nave"}, opcode_nave, m_nave);
        check_eq({tag, ":jogada_especial"}, jogada_especial, m_esp);
        check_eq({tag, ":opcodes_aste"}, opcodes_aste, m_opa);
        check_eq({tag, ":opcodes_tiro"}, opcodes_tiro, m_opt);
        check_eq({tag, ":db_estado"}, db_estado, 0);
        check_eq({tag, ":ocupado"}, ocupado, 0);
    endtask

    task automatic check_reset_state(input string tag);
        check_committed(tag);
        check_eq({tag, ":we"}, {we_mem_aste, we_mem_tiro}, 0);
        check_eq({tag, ":mem_bus"}, {endereco_mem, dado_mem}, 0);
        check_eq({tag, ":pulses"}, {quadro_valido, erro_rodape, erro_timeout}, 0);
    endtask

    // kind: 0 valid frame, 1 footer mismatch on the last byte sent, 2 silence after n_send bytes.
    task automatic run_frame(input string tag, input int kind, input int n_send,
                             input int slow_at, input bit stray);
        int a0, t0, q0, e0, x0, b0, t, na, nt;
        a0 = aste_q.size(); t0 = tiro_q.size();
        q0 = n_qv; e0 = n_er; x0 = n_et; b0 = n_both;
        n_sent = 0;
        for (int i = 0; i < n_send; i++) begin
            drive(fr[i], 1'b1);
            if (i == n_send - 1) begin
                if (stray) drive(8'h5A, 1'b0);
                idle(1);
            end else begin
                idle(1);
                check_eq({tag, ":state"}, db_estado, exp_state(i + 1));
                idle((i == slow_at) ? TO - 2 : $urandom_range(0, 5));
            end
        end
        t = 0;
        while ((n_qv + n_er + n_et) == (q0 + e0 + x0) && t < TO + 20) begin
            @(posedge clock);
            t++;
        end
        idle(4);

        na = 0; nt = 0;
        for (int i = 0; i < n_sent; i++) begin
            if (i >= P_A && i < P_A + NA) begin
                if (a0 + na < aste_q.size()) begin
                    check_eq({tag, ":aste_addr"}, aste_q[a0+na].addr, i - P_A);
                    check_eq({tag, ":aste_data"}, aste_q[a0+na].data, fr[i]);
                    check_eq({tag, ":aste_lat"}, aste_q[a0+na].cyc, edges[i]);
                end
                na++;
            end
            if (i >= P_T && i < P_T + NT) begin
                if (t0 + nt < tiro_q.size()) begin
                    check_eq({tag, ":tiro_addr"}, tiro_q[t0+nt].addr, i - P_T);
                    check_eq({tag, ":tiro_data"}, tiro_q[t0+nt].data, fr[i]);
                    check_eq({tag, ":tiro_lat"}, tiro_q[t0+nt].cyc, edges[i]);
                end
                nt++;
            end
        end
        check_eq({tag, ":aste_writes"}, aste_q.size() - a0, na);
        check_eq({tag, ":tiro_writes"}, tiro_q.size() - t0, nt);
        check_eq({tag, ":we_exclusive"}, n_both - b0, 0);
        check_eq({tag, ":quadro_valido_n"}, n_qv - q0, (kind == 0) ? 1 : 0);
        check_eq({tag, ":erro_rodape_n"}, n_er - e0, (kind == 1) ? 1 : 0);
        check_eq({tag, ":erro_timeout_n"}, n_et - x0, (kind == 2) ? 1 : 0);
        if (kind == 0) begin
            check_eq({tag, ":qv_cycle"}, cyc_qv, edges[n_sent-1]);
            m_pont = fr[0];
            m_nave = fr[1];
            m_esp  = fr[P_E];
            for (int k = 0; k < OB; k++) begin
                m_opa[8*k +: 8] = fr[O_A + k];
                m_opt[8*k +: 8] = fr[O_T + k];
            end
        end else if (kind == 1) begin
            check_eq({tag, ":er_cycle"}, cyc_er, edges[n_sent-1]);
        end else begin
            check_eq({tag, ":timeout_delay"}, cyc_et - edges[n_sent-1], TO);
        end
        check_committed(tag);
    endtask

    task automatic random_frame(input logic [7:0] score);
        for (int i = 0; i < FLEN; i++) fr[i] = 8'($urandom);
        fr[0] = score;
        for (int i = P_R; i < FLEN; i++) fr[i] = 8'hFF;
    endtask

    initial begin
        logic [7:0] plan [FLEN] = '{8'h2A, 8'h05, 8'd10, 8'd11, 8'd12, 8'd13, 8'hA5,
                                    8'd20, 8'd21, 8'h3C, 8'h01, 8'hFF, 8'hFF};
        int a0, kind, n, pos;

        repeat (3) @(posedge clock);
        #2;
        check_reset_state("reset");
        reset = 1'b0;
        idle(2);

        fr = plan;
        run_frame("plan_valid", 0, FLEN, -1, 1'b0);

        fr[FLEN-1] = 8'hFE;
        run_frame("plan_bad_footer", 1, FLEN, -1, 1'b1);

        fr = plan;
        run_frame("plan_timeout", 2, 6, -1, 1'b0);

        fr = plan;
        fr[0] = 8'h77;
        run_frame("terminal_count", 0, FLEN, 5, 1'b1);

        habilita_recepcao = 1'b0;
        a0 = aste_q.size();
        for (int i = 0; i < 5; i++) begin
            drive(8'($urandom), 1'b0);
            idle(2);
            check_eq("disabled:state", db_estado, 0);
        end
        check_eq("disabled:writes", aste_q.size() + tiro_q.size() - a0 - tiro_q.size() + tiro_q.size() - tiro_q.size(), 0);
        habilita_recepcao = 1'b1;

        for (int f = 0; f < 12; f++) begin
            random_frame(8'($urandom));
            kind = $urandom_range(0, 3);
            if (kind <= 1) begin
                run_frame("rand_valid", 0, FLEN, ($urandom_range(0, 3) == 0) ? $urandom_range(0, FLEN-2) : -1,
                          1'($urandom_range(0, 1)));
            end else if (kind == 2) begin
                pos = $urandom_range(P_R, FLEN - 1);
                fr[pos] = 8'($urandom_range(0, 254));
                run_frame("rand_bad_footer", 1, pos + 1, -1, 1'($urandom_range(0, 1)));
            end else begin
                n = $urandom_range(1, FLEN - 1);
                run_frame("rand_timeout", 2, n, -1, 1'b0);
            end
        end

        random_frame(8'h11);
        n_sent = 0;
        for (int i = 0; i < 5; i++) begin
            drive(fr[i], 1'b1);
            idle(1);
        end
        @(posedge clock); #2;
        reset = 1'b1;
        @(posedge clock); #2;
        m_pont = '0; m_nave = '0; m_esp = '0; m_opa = '0; m_opt = '0;
        check_reset_state("mid_reset");
        reset = 1'b0;
        idle(2);

        random_frame(8'hC3);
        run_frame("b2b_first", 0, FLEN, -1, 1'b0);
        random_frame(8'h3C);
        run_frame("b2b_second", 0, FLEN, -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected end before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uc_recebe_dados.md
Name: uc_recebe_dados

Overview:
Receive-side frame deframer for the game-state link. It consumes bytes from the UART receiver and parses the frame in this order: score, ship opcode, asteroid positions, asteroid opcode bytes, shot positions, shot opcode bytes, special-play byte, footer bytes.
- Position bytes are written into the asteroid and shot memories as they arrive.
- Scalar and opcode fields are staged and committed only when the footer is valid.
- It sits between uart_rx and the display/game-state datapath on the receiving board.

Parameters:
N_ASTE, 16, asteroid position bytes per frame (>=1)
N_TIROS, 16, shot position bytes per frame (>=1)
OPCODE_BYTES, 4, opcode bytes per entity group (>=1)
RODAPE_BYTES, 2, footer bytes per frame (>=1)
RODAPE_BYTE, 8'hFF, required value of every footer byte
ADDR_W, 4, memory address width; 2**ADDR_W >= max(N_ASTE,N_TIROS)
TIMEOUT_CICLOS, 500000, maximum clock cycles allowed between bytes inside a frame

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
habilita_recepcao  in  1  allows a new frame to start; sampled only in ESPERA
dado_rx  in  8  received byte; valid when pronto_rx=1
pronto_rx  in  1  one-cycle pulse per received byte
we_mem_aste  out  1  asteroid memory write enable
we_mem_tiro  out  1  shot memory write enable
endereco_mem  out  ADDR_W  write address for both memories
dado_mem  out  8  write data for both memories
pontuacao  out  8  committed score
opcode_nave  out  8  committed ship opcode
jogada_especial  out  8  committed special-play byte
opcodes_aste  out  8*OPCODE_BYTES  committed asteroid opcodes; byte k is in bits [8k+7:8k], k = arrival order
opcodes_tiro  out  8*OPCODE_BYTES  committed shot opcodes; same packing
quadro_valido  out  1  one-cycle pulse when a frame is accepted
erro_rodape  out  1  one-cycle pulse when a footer byte mismatches
erro_timeout  out  1  one-cycle pulse when inter-byte timeout expires
ocupado  out  1  high whenever the state is not ESPERA
db_estado  out  4  current state code

Behaviour:
- Reset: all outputs 0, state ESPERA, shadow registers 0, index and timeout counters 0. Reset mid-frame aborts the frame: no commit, no error pulse, memory contents left as written.
- State codes: ESPERA=0, RX_PONTUACAO=1, RX_NAVE=2, RX_POS_ASTE=3, RX_OPC_ASTE=4, RX_POS_TIRO=5, RX_OPC_TIRO=6, RX_ESPECIAL=7, RX_RODAPE=8, SINALIZA=9, ERRO=10. Unused codes go to ESPERA next cycle.
- ESPERA: if habilita_recepcao=1 and pronto_rx=1, the byte is the score. It is staged and the state moves to RX_NAVE. RX_PONTUACAO is reserved and never entered. A byte arriving while habilita_recepcao=0 is dropped.
- RX_NAVE: on pronto_rx, stage the ship opcode and go to RX_POS_ASTE.
- Position and opcode states share index register idx, which clears on every section change.
  - RX_POS_ASTE: on pronto_rx, write the byte; at idx=N_ASTE-1 go to RX_OPC_ASTE.
  - RX_OPC_ASTE: on pronto_rx, stage opcode byte idx; at idx=OPCODE_BYTES-1 go to RX_POS_TIRO.
  - RX_POS_TIRO / RX_OPC_TIRO: same rules with N_TIROS and the shot group; RX_OPC_TIRO goes to RX_ESPECIAL.
- RX_ESPECIAL: on pronto_rx, stage the byte and go to RX_RODAPE.
- RX_RODAPE:
  - A byte != RODAPE_BYTE sends the state to ERRO with cause rodape.
  - A matching byte at idx=RODAPE_BYTES-1 sends the state to SINALIZA.
- Memory write timing (registered, latency 1):
  - In the cycle after a position byte's pronto_rx, we_mem_aste or we_mem_tiro is high for exactly one cycle.
  - In that same cycle, endereco_mem=idx and dado_mem=byte.
  - The two write enables are never high together.
- Commit: on the edge entering SINALIZA, all staged fields are copied to their outputs. In SINALIZA, quadro_valido=1 for one cycle, then the state returns to ESPERA. Committed outputs hold until the next valid frame.
- ERRO: lasts one cycle. Exactly one of erro_rodape or erro_timeout is high, matching the cause. No commit occurs, outputs keep their previous values, and the state then returns to ESPERA.
- pronto_rx in SINALIZA or ERRO: the byte is dropped.
- Timeout counter:
  - Active in states 2..8 only.
  - Clears on entry to each of these states and on every pronto_rx.
  - When it reaches TIMEOUT_CICLOS-1 with pronto_rx=0, the state goes to ERRO with cause timeout.
  - If pronto_rx coincides with that terminal count, the byte wins and no timeout occurs.
- habilita_recepcao is ignored mid-frame.
- Total frame length: 3+N_ASTE+N_TIROS+2*OPCODE_BYTES+RODAPE_BYTES bytes (45 at defaults).

Test Plan:
- Valid frame. Bench parameters N_ASTE=4, N_TIROS=2, OPCODE_BYTES=1, RODAPE_BYTES=2, TIMEOUT_CICLOS=100. Send 8'h2A,8'h05,10,11,12,13,8'hA5,20,21,8'h3C,8'h01,FF,FF with 5-cycle gaps.
  -> Asteroid writes at addresses 0..3 with data 10..13; shot writes at 0..1 with data 20..21. Then pontuacao=2A, opcode_nave=05, opcodes_aste=A5, opcodes_tiro=3C, jogada_especial=01, with one quadro_valido pulse.
- Same frame with second footer byte 8'hFE -> erro_rodape pulses once; committed outputs keep their prior values; state returns to 0.
- Stop sending after the 6th byte -> erro_timeout pulses 100 cycles after the last pronto_rx; no commit.
- pronto_rx exactly on the terminal timeout cycle -> no error; the frame continues.
- habilita_recepcao=0 with bytes sent -> state stays 0 and no writes occur. Assert reset mid-frame -> all outputs 0, db_estado=0 on the next cycle.
- Two back-to-back valid frames with different scores -> two quadro_valido pulses; pontuacao updates to each value in turn.
